// File: rtl/wait_state_dmem.sv
// Data memory with a fixed wait-state delay; byte/half/word loads and stores, RISC-V funct3 sizes.
// Latency: resp_valid rises LATENCY cycles after the accept edge; at most one request in flight.
// Backpressure: response held stable until resp_ready; req_ready is low from accept to response handshake.
module wait_state_dmem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        wr_en,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] rdata,
    output logic        resp_err
);

    localparam int         IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        wr_en;
        logic [2:0]  mem_op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [31:0]      word_rd;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      ld_data;
    logic [3:0]       be;
    logic [31:0]      wd;
    logic             acc_err;
    logic             access;
    logic             mem_we;

    assign req_ready  = (state_q == IDLE) && !reset;
    assign resp_valid = (state_q == RESP);
    assign rdata      = rdata_q;
    assign resp_err   = err_q;

    assign idx     = req_q.addr[IDX_W+1:2];
    assign off     = req_q.addr[1:0];
    assign word_rd = mem[idx];
    assign access  = (state_q == WAIT) && (cnt_q == 4'd0);
    // Reset gates the write so a store aborted by reset on its access edge never lands.
    assign mem_we  = access && req_q.wr_en && !acc_err && !reset;

    // Decode the captured request: error flags, load extraction, store lane enables.
    always_comb begin
        acc_err  = 1'b0;
        ld_data  = 32'd0;
        be       = 4'b0000;
        wd       = 32'd0;
        byte_sel = word_rd[{off, 3'b000} +: 8];
        half_sel = word_rd[{off[1], 4'b0000} +: 16];
        case (req_q.mem_op)
            OP_B: begin
                ld_data = {{24{byte_sel[7]}}, byte_sel};
                be      = 4'b0001 << off;
                wd      = {4{req_q.wdata[7:0]}};
            end
            OP_BU: begin
                ld_data = {24'd0, byte_sel};
                acc_err = req_q.wr_en;
            end
            OP_H: begin
                ld_data = {{16{half_sel[15]}}, half_sel};
                be      = off[1] ? 4'b1100 : 4'b0011;
                wd      = {2{req_q.wdata[15:0]}};
                acc_err = off[0];
            end
            OP_HU: begin
                ld_data = {16'd0, half_sel};
                acc_err = off[0] || req_q.wr_en;
            end
            OP_W: begin
                ld_data = word_rd;
                be      = 4'b1111;
                wd      = req_q.wdata;
                acc_err = (off != 2'b00);
            end
            default: acc_err = 1'b1;
        endcase
        if ({2'b00, req_q.addr[31:2]} >= $unsigned(DEPTH_WORDS)) begin
            acc_err = 1'b1;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, hold response in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d   = '{wr_en: wr_en, mem_op: mem_op, addr: addr, wdata: wdata};
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = acc_err;
                    rdata_d = (acc_err || req_q.wr_en) ? 32'd0 : ld_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array: byte-lane writes on the access edge, contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wait_state_dmem.sv
// Directed bench for wait_state_dmem: LATENCY 2 (main), 1 and 15 instances.
// Expected responses come from a reference memory model and are queued at request time.
// Response timing is measured in cycles from the accept edge to resp_valid.
module tb_wait_state_dmem;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        wr_en      [3];
    logic [2:0]  mem_op     [3];
    logic [31:0] addr       [3];
    logic [31:0] wdata      [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] rdata      [3];
    logic        resp_err   [3];

    int   tests;
    int   fails;
    exp_t sbq [$];
    logic [31:0] mdl [longint];

    wait_state_dmem #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .wr_en(wr_en[0]), .mem_op(mem_op[0]), .addr(addr[0]), .wdata(wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .rdata(rdata[0]),
        .resp_err(resp_err[0]));

    wait_state_dmem #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .wr_en(wr_en[1]), .mem_op(mem_op[1]), .addr(addr[1]), .wdata(wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .rdata(rdata[1]),
        .resp_err(resp_err[1]));

    wait_state_dmem #(.DEPTH_WORDS(DEPTH), .LATENCY(15)) u_l15 (
        .clk(clk), .reset(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .wr_en(wr_en[2]), .mem_op(mem_op[2]), .addr(addr[2]), .wdata(wdata[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .rdata(rdata[2]),
        .resp_err(resp_err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int s);
        if (s == 1) return 1;
        if (s == 2) return 15;
        return 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference memory: computes the response and applies stores.
    task automatic model(input int s, input logic wr, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d, output exp_t e);
        longint      key;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          bo;
        int          ho;
        logic        bad;
        bo  = int'(a[1:0]);
        ho  = int'(a[1]);
        bad = 1'b0;
        case (op)
            3'b000: bad = 1'b0;
            3'b100: bad = wr;
            3'b001: bad = a[0];
            3'b101: bad = a[0] | wr;
            3'b010: bad = (a[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if (longint'(a[31:2]) >= longint'(DEPTH)) bad = 1'b1;
        e.rdata = 32'd0;
        e.err   = bad;
        if (!bad) begin
            key = longint'(s) * 64'd1048576 + longint'(a[31:2]);
            w   = mdl.exists(key) ? mdl[key] : 32'd0;
            b   = w[bo*8 +: 8];
            h   = w[ho*16 +: 16];
            if (wr) begin
                case (op)
                    3'b000:  w[bo*8 +: 8]   = d[7:0];
                    3'b001:  w[ho*16 +: 16] = d[15:0];
                    default: w              = d;
                endcase
                mdl[key] = w;
            end else begin
                case (op)
                    3'b000:  e.rdata = {{24{b[7]}}, b};
                    3'b100:  e.rdata = {24'd0, b};
                    3'b001:  e.rdata = {{16{h[15]}}, h};
                    3'b101:  e.rdata = {16'd0, h};
                    default: e.rdata = w;
                endcase
            end
        end
    endtask

    // One complete transaction; hold>0 withholds resp_ready and pokes req_valid meanwhile.
    task automatic send(input int s, input logic wr, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] d, input int hold);
        exp_t e;
        exp_t got;
        int   n;
        model(s, wr, op, a, d, e);
        sbq.push_back(e);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[s]), 32'd1);
        req_valid[s] = 1'b1;
        wr_en[s]     = wr;
        mem_op[s]    = op;
        addr[s]      = a;
        wdata[s]     = d;
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        wr_en[s]     = ~wr;
        mem_op[s]    = 3'b111;
        addr[s]      = $urandom;
        wdata[s]     = $urandom;
        chk("req_ready_busy", 32'(req_ready[s]), 32'd0);
        n = 0;
        while (!resp_valid[s] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("latency_l%0d", lat_of(s)), 32'(n), 32'(lat_of(s)));
        got = sbq.pop_front();
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid[s]), 32'd1);
        chk("rdata", rdata[s], got.rdata);
        chk("resp_err", 32'(resp_err[s]), 32'(got.err));
        for (int i = 0; i < hold; i++) begin
            req_valid[s] = 1'b1;
            wr_en[s]     = 1'b1;
            mem_op[s]    = 3'b010;
            addr[s]      = 32'h40;
            wdata[s]     = 32'hBADBAD00;
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid[s]), 32'd1);
            chk("bp_rdata", rdata[s], got.rdata);
            chk("bp_resp_err", 32'(resp_err[s]), 32'(got.err));
            chk("bp_req_ready", 32'(req_ready[s]), 32'd0);
        end
        req_valid[s]  = 1'b0;
        resp_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[s] = 1'b0;
        chk("post_hs_resp_valid", 32'(resp_valid[s]), 32'd0);
        chk("post_hs_req_ready", 32'(req_ready[s]), 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid[i]  = 1'b0;
            wr_en[i]      = 1'b0;
            mem_op[i]     = 3'b000;
            addr[i]       = 32'd0;
            wdata[i]      = 32'd0;
            resp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_resp_err", 32'(resp_err[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(req_ready[0]), 32'd1);

        // Word store/load and sub-word lanes
        send(0, 1'b1, 3'b010, 32'h40, 32'h12345678, 0);
        send(0, 1'b0, 3'b010, 32'h40, 32'h0, 0);
        send(0, 1'b1, 3'b000, 32'h40, 32'hFFFFFFAA, 0);
        send(0, 1'b0, 3'b010, 32'h40, 32'h0, 0);
        send(0, 1'b0, 3'b100, 32'h41, 32'h0, 0);
        send(0, 1'b0, 3'b101, 32'h42, 32'h0, 0);
        send(0, 1'b0, 3'b000, 32'h40, 32'h0, 0);
        send(0, 1'b1, 3'b001, 32'h46, 32'hCAFE8001, 0);
        send(0, 1'b0, 3'b001, 32'h46, 32'h0, 0);
        send(0, 1'b0, 3'b000, 32'h43, 32'h0, 0);

        // Error cases, then confirm word 0x40 untouched
        send(0, 1'b0, 3'b010, 32'h42, 32'h0, 0);
        send(0, 1'b0, 3'b001, 32'h41, 32'h0, 0);
        send(0, 1'b1, 3'b100, 32'h40, 32'h000000EE, 0);
        send(0, 1'b0, 3'b010, DEPTH * 4, 32'h0, 0);
        send(0, 1'b0, 3'b011, 32'h40, 32'h0, 0);
        send(0, 1'b0, 3'b010, 32'h40, 32'h0, 0);

        // Backpressure with ignored request, then verify no stray write
        send(0, 1'b0, 3'b010, 32'h40, 32'h0, 5);
        @(negedge clk);
        chk("bp_no_new_resp", 32'(resp_valid[0]), 32'd0);
        send(0, 1'b0, 3'b010, 32'h40, 32'h0, 0);

        // Latency extremes
        send(1, 1'b1, 3'b010, 32'h80, 32'hA5A5_0F0F, 0);
        send(1, 1'b0, 3'b010, 32'h80, 32'h0, 0);
        send(2, 1'b1, 3'b010, 32'h80, 32'h0BAD_F00D, 0);
        send(2, 1'b0, 3'b010, 32'h80, 32'h0, 0);

        // Reset in the middle of a store's wait window
        @(negedge clk);
        req_valid[0] = 1'b1;
        wr_en[0]     = 1'b1;
        mem_op[0]    = 3'b010;
        addr[0]      = 32'h40;
        wdata[0]     = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst          = 1'b1;
        #1;
        chk("midwait_req_ready", 32'(req_ready[0]), 32'd0);
        chk("midwait_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("midwait_rdata", rdata[0], 32'd0);
        chk("midwait_resp_err", 32'(resp_err[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midwait_release_ready", 32'(req_ready[0]), 32'd1);
        send(0, 1'b0, 3'b010, 32'h40, 32'h0, 0);
        send(1, 1'b0, 3'b010, 32'h80, 32'h0, 0);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wait_state_dmem.md
WAIT_STATE_DMEM -- requirements
Module: wait_state_dmem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from request accept to response valid; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the CPU is presenting a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 The block SHALL have port wr_en, input, 1 bit: the request is a store (1) or a load (0).
REQ-008 The block SHALL have port mem_op, input, 3 bits, RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 The block SHALL have port addr, input, 32 bits: the byte address.
REQ-010 The block SHALL have port wdata, input, 32 bits: the store data, with the value in the low bits.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: the response is present.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: the CPU accepts the response.
REQ-013 The block SHALL have port rdata, output, 32 bits: the extended load data; 0 for stores and errors.
REQ-014 The block SHALL have port resp_err, output, 1 bit: the request was misaligned, out of range or illegal.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 In IDLE the block SHALL drive req_ready=1; in WAIT and RESP it SHALL drive req_ready=0.
REQ-017 When req_valid&&req_ready, the block SHALL capture wr_en, mem_op, addr and wdata, and SHALL ignore later input changes for that request.
REQ-018 On accept the block SHALL enter WAIT, load the latency counter with LATENCY-1, and decrement it each cycle in WAIT.
REQ-019 When the counter equals 0 in WAIT, the block SHALL perform the access on that edge and enter RESP; resp_valid SHALL rise exactly LATENCY cycles after the accept edge.
REQ-020 In RESP the block SHALL hold resp_valid, rdata and resp_err stable until resp_ready=1, then return to IDLE on that edge.
REQ-021 The block SHALL accept the next request no earlier than the cycle after the response handshake, giving at most one outstanding request.
REQ-022 For B/BU the byte lane SHALL be addr[1:0]; for H/HU the half lane SHALL be addr[1]; W SHALL use the full word.
REQ-023 Loads SHALL sign-extend B and H and zero-extend BU and HU.
REQ-024 Stores SHALL write only the selected byte lanes, using wdata[7:0] for B and wdata[15:0] for H, and SHALL leave other lanes unchanged.
REQ-025 The block SHALL flag an error for any of these conditions:
- H/HU with addr[0]=1.
- W with addr[1:0]≠00.
- Word index addr[31:2] ≥ DEPTH_WORDS.
- mem_op in {011, 110, 111}.
- A store with BU or HU.
REQ-026 An erroring request SHALL follow the same LATENCY timing, write nothing, and return resp_err=1 with rdata=0.
REQ-027 A store response SHALL return resp_err=0 and rdata=0.
REQ-028 A store followed by a load of the same address SHALL return the stored data, with no forwarding hazard because requests are serialized.
REQ-029 req_valid asserted while req_ready=0 SHALL have no effect.

Reset
REQ-030 While reset=1, the block SHALL asynchronously force the state to IDLE, the counter to 0, resp_valid=0, resp_err=0, rdata=0 and req_ready=0.
REQ-031 req_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-032 Reset asserted in WAIT SHALL abort the request; a pending store SHALL NOT be written.
REQ-033 The storage array SHALL NOT be cleared by reset.

Verification
REQ-034 The bench SHALL cover: SW 0x12345678 @0x40, then LW @0x40 -> rdata=0x12345678, resp_err=0, resp_valid exactly 2 cycles after each accept.
REQ-035 The bench SHALL cover: SB wdata=0xFFFFFFAA @0x40, then LW @0x40 -> 0x123456AA; LBU @0x41 -> 0x00000056; LHU @0x42 -> 0x00001234; LB @0x40 -> 0xFFFFFFAA.
REQ-036 The bench SHALL cover: LW @0x42, LH @0x41, SB with mem_op=100, and LW @ DEPTH_WORDS*4 -> resp_err=1 and rdata=0 on each, with word 0x40 unchanged afterwards.
REQ-037 The bench SHALL cover backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable, req_ready=0, and a new req_valid ignored; on resp_ready=1, IDLE follows.
REQ-038 The bench SHALL cover reset mid-WAIT of SW 0xDEADBEEF @0x40 -> outputs reset, and a later LW @0x40 returns the prior value.
REQ-039 The bench SHALL cover LATENCY=1 and LATENCY=15 builds, with resp_valid rising exactly 1 and 15 cycles after accept respectively.
